// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, drives the imem address and buffers {pc, instr} in a 2-entry FIFO for decode.
// Latency: enable -> first push next cycle -> instr_valid_o the cycle after; 1 instr/cycle sustained.
// Backpressure: FIFO full with instr_ready_i=0 stalls fetch (PC holds); redirect flushes and overrides everything.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          IMEM_POS  = 4096,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        enable_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_pc_o,
    input  logic [31:0] imem_instr_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        fault_o,
    output logic [31:0] fetched_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    // The buffer is hard-wired to two slots; the imem wraps its own index.
    if (BUF_DEPTH != 2 || IMEM_POS <= 0 || (IMEM_POS & (IMEM_POS - 1)) != 0) begin : g_param_check
        $error("imem_fetch_ctrl: BUF_DEPTH must be 2 and IMEM_POS a power of two");
    end

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    entry_t      buf_q [2];
    entry_t      buf_d [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] fetched_cnt_q, fetched_cnt_d;

    logic        pop;
    logic        push;
    entry_t      head;

    always_comb begin
        pop  = (count_q != 2'd0) && instr_ready_i;
        // A pop in the same cycle frees the slot the push lands in.
        push = (state_q == ST_RUN) && !redirect_i && ((count_q != 2'd2) || pop);

        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        buf_d         = buf_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q + {1'b0, push} - {1'b0, pop};
        fetched_cnt_d = fetched_cnt_q;

        if (pop) begin
            rd_ptr_d      = ~rd_ptr_q;
            fetched_cnt_d = fetched_cnt_q + 32'd1;
        end

        if (push) begin
            buf_d[wr_ptr_q] = '{pc: fetch_pc_q, instr: imem_instr_i};
            wr_ptr_d        = ~wr_ptr_q;
            fetch_pc_d      = fetch_pc_q + 32'd4;
        end

        if (redirect_i) begin
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            fetch_pc_d = redirect_pc_i;
            if (redirect_pc_i[1:0] != 2'b00) begin
                state_d = ST_FAULT;
            end else begin
                state_d = enable_i ? ST_RUN : ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE:  if (enable_i)  state_d = ST_RUN;
                ST_RUN:   if (!enable_i) state_d = ST_IDLE;
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC;
            buf_q[0]      <= '0;
            buf_q[1]      <= '0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            fetched_cnt_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            buf_q[0]      <= buf_d[0];
            buf_q[1]      <= buf_d[1];
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            fetched_cnt_q <= fetched_cnt_d;
        end
    end

    assign head          = buf_q[rd_ptr_q];
    assign imem_pc_o     = fetch_pc_q;
    assign instr_valid_o = (count_q != 2'd0);
    assign instr_o       = instr_valid_o ? head.instr : 32'd0;
    assign pc_o          = instr_valid_o ? head.pc : 32'd0;
    assign fault_o       = (state_q == ST_FAULT);
    assign fetched_cnt_o = fetched_cnt_q;

endmodule
